// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the encrypt and decrypt datapaths.
package aes_pkg;

    // 16-byte AES state; byte 0 occupies bits 7:0, bytes 0-3 form column 0.
    typedef logic [15:0][7:0] aes_state_t;

    // Iterative decrypt controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } dec_fsm_e;

    // Forward S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of repeated xtime terms.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2  = xtime(a);
        x4  = xtime(x2);
        x8  = xtime(x4);
        res = 8'h00;
        if (c[0]) res ^= a;
        if (c[1]) res ^= x2;
        if (c[2]) res ^= x4;
        if (c[3]) res ^= x8;
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse-cipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] next_state
);

    aes_state_t state_in;
    aes_state_t key_in;
    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;
    aes_state_t mixed;

    assign state_in = state;
    assign key_in   = round_key;

    genvar gi;
    generate
        // Per-byte: row r rotates right by r, then inverse S-box, then key add.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign shifted[gi] = state_in[SRC];
            assign subbed[gi]  = INV_SBOX[shifted[gi]];
            assign keyed[gi]   = subbed[gi] ^ key_in[gi];
        end

        // Per-column inverse mix with the circulant {0e,0b,0d,09}.
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mixed[4*gi+0] = gmul(keyed[4*gi+0], 4'd14) ^ gmul(keyed[4*gi+1], 4'd11)
                                 ^ gmul(keyed[4*gi+2], 4'd13) ^ gmul(keyed[4*gi+3], 4'd9);
            assign mixed[4*gi+1] = gmul(keyed[4*gi+0], 4'd9)  ^ gmul(keyed[4*gi+1], 4'd14)
                                 ^ gmul(keyed[4*gi+2], 4'd11) ^ gmul(keyed[4*gi+3], 4'd13);
            assign mixed[4*gi+2] = gmul(keyed[4*gi+0], 4'd13) ^ gmul(keyed[4*gi+1], 4'd9)
                                 ^ gmul(keyed[4*gi+2], 4'd14) ^ gmul(keyed[4*gi+3], 4'd11);
            assign mixed[4*gi+3] = gmul(keyed[4*gi+0], 4'd11) ^ gmul(keyed[4*gi+1], 4'd13)
                                 ^ gmul(keyed[4*gi+2], 4'd9)  ^ gmul(keyed[4*gi+3], 4'd14);
        end
    endgenerate

    assign next_state = last_round ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys
// fetched from an external key store addressed by rk_idx.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] LAST_KEY = 4'(NR);

    dec_fsm_e     fsm_reg;
    logic [3:0]   rnd_reg;
    aes_state_t   state_reg;
    logic [127:0] out_data_reg;
    logic         out_valid_reg;
    logic         in_ready_reg;
    logic         busy_reg;
    logic [3:0]   rk_idx_reg;
    logic [127:0] round_out;

    aes_inv_round u_round (
        .state      (state_reg),
        .round_key  (rk_in),
        .last_round (rnd_reg == 4'd0),
        .next_state (round_out)
    );

    // Controller: load/whiten, iterate rounds, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            rnd_reg       <= 4'd0;
            state_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            rk_idx_reg    <= LAST_KEY;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= in_data ^ rk_in;
                        rnd_reg      <= LAST_KEY - 4'd1;
                        rk_idx_reg   <= LAST_KEY - 4'd1;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        fsm_reg      <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (rnd_reg == 4'd0) begin
                        out_data_reg  <= round_out;
                        out_valid_reg <= 1'b1;
                        rk_idx_reg    <= LAST_KEY;
                        fsm_reg       <= DONE;
                    end else begin
                        rnd_reg    <= rnd_reg - 4'd1;
                        rk_idx_reg <= rnd_reg - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_data_reg  <= '0;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign rk_idx    = rk_idx_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter: a forward-cipher model produces
// ciphertext from random plaintext; the plaintext is the expected result.
module tb_aes_decrypt_iter;

    typedef logic [15:0][7:0] blk_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk_store [11];
    logic [127:0] sb_q [$];
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int unsigned  cyc   = 0;

    aes_decrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    assign rk_in = (rk_idx <= 4'd10) ? rk_store[rk_idx] : 128'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic blk_t brev(input logic [127:0] x);
        blk_t r;
        blk_t v;
        v = x;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // FIPS-197 key expansion into the 11-entry round-key store.
    task automatic load_key(input logic [127:0] key);
        logic [7:0] rcon;
        blk_t p;
        blk_t n;
        logic [7:0] t0, t1, t2, t3;
        rcon = 8'h01;
        rk_store[0] = key;
        for (int r = 1; r <= 10; r++) begin
            p  = rk_store[r-1];
            t0 = aes_pkg::SBOX[p[13]] ^ rcon;
            t1 = aes_pkg::SBOX[p[14]];
            t2 = aes_pkg::SBOX[p[15]];
            t3 = aes_pkg::SBOX[p[12]];
            for (int c = 0; c < 4; c++) begin
                n[4*c+0] = p[4*c+0] ^ t0;
                n[4*c+1] = p[4*c+1] ^ t1;
                n[4*c+2] = p[4*c+2] ^ t2;
                n[4*c+3] = p[4*c+3] ^ t3;
                t0 = n[4*c+0];
                t1 = n[4*c+1];
                t2 = n[4*c+2];
                t3 = n[4*c+3];
            end
            rk_store[r] = n;
            rcon = xt(rcon);
        end
    endtask

    // Forward cipher with the current key store.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        blk_t s;
        blk_t t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk_store[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = aes_pkg::SBOX[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c+0]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c+0] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rk_store[r];
        end
        return s;
    endfunction

    // Offer one block, record its expected plaintext, follow rk_idx and latency.
    task automatic send_block(input logic [127:0] ct, input logic [127:0] pt,
                              input bit hold, output int unsigned acc);
        int n;
        n = 0;
        in_data  = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready_idle", 128'(in_ready), 128'(1));
        chk("rk_idx_idle", 128'(rk_idx), 128'(10));
        sb_q.push_back(pt);
        tick();
        acc = cyc;
        if (!hold) in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            chk("rk_idx_round", 128'(rk_idx), 128'(10 - n));
            tick();
            n++;
        end
        chk("latency_edges", 128'(n), 128'(11));
    endtask

    // Output monitor: idle output must be zero; each handshake pops the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !out_valid)
            chk("out_data_idle", out_data, 128'h0);
        if (rst_n && out_valid && out_ready) begin
            chk("sb_occupancy", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0)
                chk("plaintext", out_data, sb_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int unsigned prev_acc;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] key;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) rk_store[i] = '0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_rk_idx", 128'(rk_idx), 128'(10));
        chk("post_rst_busy", 128'(busy), 128'(0));

        // FIPS-197 C.1
        load_key(brev(128'h000102030405060708090a0b0c0d0e0f));
        send_block(128'h5ac5b47080b7cdd830047b6ad8e0c469,
                   128'hffeeddccbbaa99887766554433221100, 1'b0, acc);
        chk("c1_busy_done", 128'(busy), 128'(1));
        tick();
        tick();

        // FIPS-197 Appendix B
        load_key(brev(128'h2b7e151628aed2a6abf7158809cf4f3c));
        send_block(brev(128'h3925841d02dc09fbdc118597196a0b32),
                   brev(128'h3243f6a8885a308d313198a2e0370734), 1'b0, acc);
        tick();
        tick();

        // Back-pressure: hold DONE for 20 cycles with in_valid pulses.
        out_ready = 1'b0;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        load_key(key);
        ct = encrypt(pt);
        send_block(ct, pt, 1'b0, acc);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_out_data", out_data, pt);
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", 128'(out_valid), 128'(0));
        chk("release_in_ready", 128'(in_ready), 128'(1));
        chk("release_busy", 128'(busy), 128'(0));
        repeat (3) tick();

        // Reset while ROUND with counter 4.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        load_key(key);
        in_data  = encrypt(pt);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && rk_idx != 4'd4; n++) tick();
        chk("rk_at_reset", 128'(rk_idx), 128'(4));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_out_data", out_data, 128'h0);
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_rk_idx", 128'(rk_idx), 128'(10));
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("no_spurious_valid", 128'(out_valid), 128'(0));
        end
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        load_key(key);
        send_block(encrypt(pt), pt, 1'b0, acc);
        tick();
        tick();

        // Back-to-back random blocks with in_valid and out_ready held high.
        prev_acc = 0;
        for (int b = 0; b < 1000; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            load_key(key);
            ct = encrypt(pt);
            send_block(ct, pt, 1'b1, acc);
            if (b > 0) chk("accept_period", 128'(acc - prev_acc), 128'(12));
            prev_acc = acc;
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
